// File: rtl/lc3_mem_pkg.sv
// Shared constants and types for the LC-3 MAR/MDR memory interface.
package lc3_mem_pkg;

   localparam int unsigned WORD_W             = 16;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      DONE    = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for a memory transaction; last_c flags the final cycle
// that may still complete normally before the transaction is abandoned.
module mem_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // This stall is the one that brings the count up to TIMEOUT_CYCLES.
   assign last_c = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mar_mdr_mem_if.sv
// LC-3 MAR/MDR capture and single-word memory read/write sequencer.
// Define MEM_TIMEOUT_EN to abandon transactions after TIMEOUT_CYCLES stalls.
module mar_mdr_mem_if #(
   parameter int unsigned WORD_W         = lc3_mem_pkg::WORD_W,
   parameter int unsigned TIMEOUT_CYCLES = lc3_mem_pkg::TIMEOUT_CYCLES_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [WORD_W-1:0] Bus_in,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              MIO_EN,
   input  logic              Rd_req,
   input  logic              Wr_req,
   input  logic [WORD_W-1:0] Mem_rdata,
   input  logic              Mem_ready,
   output logic [WORD_W-1:0] MAR,
   output logic [WORD_W-1:0] MDR,
   output logic [WORD_W-1:0] Mem_addr,
   output logic [WORD_W-1:0] Mem_wdata,
   output logic              Mem_ce,
   output logic              Mem_we,
   output logic              Busy,
   output logic              Done,
   output logic              Err
);

   import lc3_mem_pkg::*;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("mar_mdr_mem_if: TIMEOUT_CYCLES must be nonzero");
   end

   mem_state_t        state;
   logic [WORD_W-1:0] mar_q;
   logic [WORD_W-1:0] mdr_q;
   logic              ce_q;
   logic              we_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              in_wait_c;
   logic              tmo_last_c;

   assign in_wait_c = (state == RD_WAIT) || (state == WR_WAIT);

`ifdef MEM_TIMEOUT_EN
   mem_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (Clk),
      .rst    (Reset),
      .clr    (!in_wait_c),
      .en     (in_wait_c && !Mem_ready),
      .last_c (tmo_last_c)
   );
`else
   assign tmo_last_c = 1'b0;
`endif

   // Register loads happen only in IDLE; the handshake outputs are set on the
   // edge that enters each state so every output is a flop.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         mar_q  <= '0;
         mdr_q  <= '0;
         ce_q   <= 1'b0;
         we_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (LD_MAR) begin
                  mar_q <= Bus_in;
               end
               if (LD_MDR && !MIO_EN) begin
                  mdr_q <= Bus_in;
               end
               if (Rd_req) begin
                  state  <= RD_WAIT;
                  ce_q   <= 1'b1;
                  we_q   <= 1'b0;
                  busy_q <= 1'b1;
               end else if (Wr_req) begin
                  state  <= WR_WAIT;
                  ce_q   <= 1'b1;
                  we_q   <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            RD_WAIT: begin
               if (Mem_ready || tmo_last_c) begin
                  state  <= DONE;
                  ce_q   <= 1'b0;
                  we_q   <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  err_q  <= !Mem_ready;
                  if (Mem_ready) begin
                     mdr_q <= Mem_rdata;
                  end
               end
            end
            WR_WAIT: begin
               if (Mem_ready || tmo_last_c) begin
                  state  <= DONE;
                  ce_q   <= 1'b0;
                  we_q   <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  err_q  <= !Mem_ready;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               ce_q   <= 1'b0;
               we_q   <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign MAR       = mar_q;
   assign MDR       = mdr_q;
   assign Mem_addr  = mar_q;
   assign Mem_wdata = mdr_q;
   assign Mem_ce    = ce_q;
   assign Mem_we    = we_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Err       = err_q;

endmodule

// File: tb/tb_mar_mdr_mem_if.sv
// Self-checking bench for mar_mdr_mem_if: directed scenarios plus randomized
// transactions against a transaction-level model of MAR/MDR.
module tb_mar_mdr_mem_if;

   localparam int unsigned W   = 16;
   localparam int unsigned TMO = 4;

   logic         Clk = 1'b0;
   logic         Reset;
   logic [W-1:0] Bus_in;
   logic         LD_MAR, LD_MDR, MIO_EN, Rd_req, Wr_req, Mem_ready;
   logic [W-1:0] Mem_rdata;
   logic [W-1:0] MAR, MDR, Mem_addr, Mem_wdata;
   logic         Mem_ce, Mem_we, Busy, Done, Err;

   int total = 0;
   int bad   = 0;

   // transaction-level model of the two architectural registers
   logic [W-1:0] mar_m = '0;
   logic [W-1:0] mdr_m = '0;

   mar_mdr_mem_if #(.WORD_W(W), .TIMEOUT_CYCLES(TMO)) dut (
      .Clk(Clk), .Reset(Reset), .Bus_in(Bus_in), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
      .MIO_EN(MIO_EN), .Rd_req(Rd_req), .Wr_req(Wr_req), .Mem_rdata(Mem_rdata),
      .Mem_ready(Mem_ready), .MAR(MAR), .MDR(MDR), .Mem_addr(Mem_addr),
      .Mem_wdata(Mem_wdata), .Mem_ce(Mem_ce), .Mem_we(Mem_we), .Busy(Busy),
      .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_load(input logic [W-1:0] bus, input bit lmar, input bit lmdr, input bit mio);
      Bus_in = bus; LD_MAR = lmar; LD_MDR = lmdr; MIO_EN = mio;
      tick();
      LD_MAR = 0; LD_MDR = 0; MIO_EN = 0;
      if (lmar) mar_m = bus;
      if (lmdr && !mio) mdr_m = bus;
   endtask

   // Issue one request, stall dly cycles, complete it; report what was seen.
   task automatic do_txn(input bit rd, input bit wr, input bit lmar, input logic [W-1:0] bus,
                         input int dly, input logic [W-1:0] rdata, input bit noise,
                         output int n_done, output bit ce_held, output bit we_seen,
                         output logic [W-1:0] addr_seen, output logic [W-1:0] wdata_seen,
                         output bit done_prompt, output bit busy_after);
      Rd_req = rd; Wr_req = wr; LD_MAR = lmar; Bus_in = bus;
      tick();
      Rd_req = 0; Wr_req = 0; LD_MAR = 0;
      if (noise) begin
         Rd_req = 1; Wr_req = 1; LD_MAR = 1; LD_MDR = 1; MIO_EN = 0; Bus_in = 16'hFFFF;
      end
      n_done = 0; ce_held = 1; we_seen = 0; busy_after = 0;
      for (int i = 0; i < dly; i++) begin
         if (!Mem_ce) ce_held = 0;
         if (Mem_we) we_seen = 1;
         if (Done) n_done++;
         tick();
      end
      if (!Mem_ce) ce_held = 0;
      if (Mem_we) we_seen = 1;
      addr_seen = Mem_addr; wdata_seen = Mem_wdata;
      Mem_ready = 1; Mem_rdata = rdata;
      tick();
      Mem_ready = 0; Mem_rdata = W'($urandom);
      done_prompt = Done && !Busy && !Mem_ce && !Err;
      if (Done) n_done++;
      tick();
      if (Done) n_done++;
      if (Busy) busy_after = 1;
      Rd_req = 0; Wr_req = 0; LD_MAR = 0; LD_MDR = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (Done) n_done++;
      end
   endtask

   task automatic test_reset();
      Reset = 1;
      tick(); tick();
      total++; if (MAR !== 16'h0000) begin bad++; $display("FAIL reset_mar got=%h want=0000", MAR); end
      total++; if (MDR !== 16'h0000) begin bad++; $display("FAIL reset_mdr got=%h want=0000", MDR); end
      total++; if ({Mem_ce, Mem_we, Busy, Done, Err} !== 5'b0) begin
         bad++; $display("FAIL reset_ctl got=%b want=00000", {Mem_ce, Mem_we, Busy, Done, Err});
      end
      Reset = 0;
      tick();
      total++; if ({Mem_ce, Busy, Done} !== 3'b0) begin bad++; $display("FAIL idle_ctl got=%b want=000", {Mem_ce, Busy, Done}); end
   endtask

   task automatic test_read();
      int nd; bit ce, we, dp, ba; logic [W-1:0] a, wd;
      idle_load(16'h3000, 1, 0, 0);
      do_txn(1, 0, 0, 16'h0, 3, 16'hBEEF, 0, nd, ce, we, a, wd, dp, ba);
      mdr_m = 16'hBEEF;
      total++; if (a !== 16'h3000) begin bad++; $display("FAIL read_addr got=%h want=3000", a); end
      total++; if (!ce || we) begin bad++; $display("FAIL read_ce_we got=%b%b want=10", ce, we); end
      total++; if (MDR !== mdr_m) begin bad++; $display("FAIL read_mdr got=%h want=%h", MDR, mdr_m); end
      total++; if (nd !== 1 || !dp) begin bad++; $display("FAIL read_done got=%0d/%b want=1/1", nd, dp); end
   endtask

   task automatic test_write();
      int nd; bit ce, we, dp, ba; logic [W-1:0] a, wd;
      idle_load(16'h3001, 1, 0, 0);
      idle_load(16'h1234, 0, 1, 0);
      idle_load(16'h5555, 0, 1, 1);
      total++; if (MDR !== 16'h1234) begin bad++; $display("FAIL mio_blocks_ld got=%h want=1234", MDR); end
      do_txn(0, 1, 0, 16'h0, 1, 16'hDEAD, 0, nd, ce, we, a, wd, dp, ba);
      total++; if (!we || !ce) begin bad++; $display("FAIL write_we got=%b%b want=11", ce, we); end
      total++; if (wd !== 16'h1234 || a !== 16'h3001) begin bad++; $display("FAIL write_bus got=%h/%h want=3001/1234", a, wd); end
      total++; if (MDR !== 16'h1234) begin bad++; $display("FAIL write_mdr got=%h want=1234", MDR); end
      total++; if (nd !== 1 || !dp) begin bad++; $display("FAIL write_done got=%0d/%b want=1/1", nd, dp); end
   endtask

   task automatic test_collision();
      int nd; bit ce, we, dp, ba; logic [W-1:0] a, wd;
      do_txn(1, 1, 1, 16'h2222, 2, 16'hA5A5, 1, nd, ce, we, a, wd, dp, ba);
      mar_m = 16'h2222; mdr_m = 16'hA5A5;
      total++; if (we) begin bad++; $display("FAIL coll_we got=1 want=0"); end
      total++; if (a !== 16'h2222) begin bad++; $display("FAIL coll_addr got=%h want=2222", a); end
      total++; if (MAR !== mar_m) begin bad++; $display("FAIL busy_ld_mar got=%h want=%h", MAR, mar_m); end
      total++; if (MDR !== mdr_m) begin bad++; $display("FAIL coll_mdr got=%h want=%h", MDR, mdr_m); end
      total++; if (nd !== 1 || ba) begin bad++; $display("FAIL coll_done got=%0d/%b want=1/0", nd, ba); end
   endtask

   task automatic test_back_to_back();
      Rd_req = 1; Mem_ready = 1; Mem_rdata = 16'h0F0F;
      tick();
      Rd_req = 0;
      total++; if (!Mem_ce || !Busy) begin bad++; $display("FAIL b2b_ce got=%b%b want=11", Mem_ce, Busy); end
      tick();
      total++; if (!Done || MDR !== 16'h0F0F) begin bad++; $display("FAIL b2b_done got=%b/%h want=1/0f0f", Done, MDR); end
      Rd_req = 1; Mem_rdata = 16'hF0F0;
      tick();
      total++; if ({Busy, Mem_ce, Done} !== 3'b000) begin bad++; $display("FAIL b2b_done_ignores got=%b want=000", {Busy, Mem_ce, Done}); end
      tick();
      total++; if ({Busy, Mem_ce} !== 2'b11) begin bad++; $display("FAIL b2b_next got=%b want=11", {Busy, Mem_ce}); end
      Rd_req = 0;
      tick();
      Mem_ready = 0;
      total++; if (!Done || MDR !== 16'hF0F0) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/f0f0", Done, MDR); end
      mdr_m = 16'hF0F0;
      tick(); tick();
   endtask

   task automatic test_reset_abort();
      idle_load(16'h4444, 1, 0, 0);
      idle_load(16'h7777, 0, 1, 0);
      Rd_req = 1;
      tick();
      Rd_req = 0;
      tick();
      Reset = 1;
      #1;
      total++; if ({Mem_ce, Busy, Done} !== 3'b000) begin bad++; $display("FAIL abort_ctl got=%b want=000", {Mem_ce, Busy, Done}); end
      total++; if (MDR !== 16'h0000 || MAR !== 16'h0000) begin bad++; $display("FAIL abort_regs got=%h/%h want=0000/0000", MAR, MDR); end
      Mem_ready = 1; Mem_rdata = 16'h9999;
      tick(); tick();
      Reset = 0;
      tick(); tick();
      Mem_ready = 0;
      total++; if (Done || Busy || MDR !== 16'h0000) begin bad++; $display("FAIL abort_after got=%b%b/%h want=00/0000", Done, Busy, MDR); end
      mar_m = '0; mdr_m = '0;
   endtask

   task automatic test_random();
      int nd, dly, op; bit ce, we, dp, ba, lm, nz; logic [W-1:0] a, wd, bus, rdat;
      for (int it = 0; it < 40; it++) begin
         idle_load(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         op = $urandom_range(1, 3); dly = $urandom_range(0, 3);
         lm = 1'($urandom); nz = 1'($urandom); bus = W'($urandom); rdat = W'($urandom);
         do_txn(op != 2, op != 1, lm, bus, dly, rdat, nz, nd, ce, we, a, wd, dp, ba);
         if (lm) mar_m = bus;
         if (op != 2) mdr_m = rdat;
         total++; if (MAR !== mar_m || MDR !== mdr_m) begin
            bad++; $display("FAIL rnd_regs it=%0d got=%h/%h want=%h/%h", it, MAR, MDR, mar_m, mdr_m);
         end
         total++; if (a !== mar_m || we !== (op == 2) || !ce) begin
            bad++; $display("FAIL rnd_bus it=%0d got=%h/%b/%b want=%h/%b/1", it, a, we, ce, mar_m, op == 2);
         end
         total++; if (nd !== 1 || !dp || ba || Err) begin
            bad++; $display("FAIL rnd_done it=%0d got=%0d/%b/%b/%b want=1/1/0/0", it, nd, dp, ba, Err);
         end
      end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      logic [W-1:0] keep;
      keep = mdr_m;
      Rd_req = 1;
      tick();
      Rd_req = 0;
      for (int i = 0; i < TMO - 1; i++) tick();
      total++; if (Done) begin bad++; $display("FAIL tmo_early got=1 want=0"); end
      tick();
      total++; if (!Done || !Err || MDR !== keep) begin
         bad++; $display("FAIL tmo_fire got=%b%b/%h want=11/%h", Done, Err, MDR, keep);
      end
      tick(); tick();
      Rd_req = 1;
      tick();
      Rd_req = 0;
      for (int i = 0; i < TMO - 1; i++) tick();
      Mem_ready = 1; Mem_rdata = 16'h6C6C;
      tick();
      Mem_ready = 0;
      total++; if (!Done || Err || MDR !== 16'h6C6C) begin
         bad++; $display("FAIL tmo_ready_wins got=%b%b/%h want=10/6c6c", Done, Err, MDR);
      end
      mdr_m = 16'h6C6C;
      tick(); tick();
   endtask
`endif

   initial begin
      Reset = 1; Bus_in = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0;
      Rd_req = 0; Wr_req = 0; Mem_ready = 0; Mem_rdata = '0;
      test_reset();
      test_read();
      test_write();
      test_collision();
      test_back_to_back();
      test_reset_abort();
      test_random();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
